// File: rtl/usr_nbit.sv
`default_nettype none
// ============================================================================
// Module   : usr_nbit
// Purpose  : Parametrised N-bit universal shift register. Per cycle it can
//            hold, shift right/left, rotate right/left, parallel-load or
//            clear. A serial-shift counter and a one-cycle word-ready pulse
//            mark each completed N-bit serial word, so the block works as a
//            SIPO deserializer, PISO serializer or SISO delay line.
// Ports    : clk            - clock, all state changes on rising edge
//            reset_ah_in    - synchronous active-high reset
//            en_in          - clock enable (0 = hold, word_ready forced low)
//            mode_in[2:0]   - operation select
//            sr_in / sl_in  - serial inputs for shift right / shift left
//            d_par_in[N-1:0]- parallel load data
//            q_par_out      - register contents
//            sr_out/sl_out  - q[0] / q[N-1]
//            cnt_out[CW-1:0]- serial shifts since last load/clear/wrap
//            word_ready_out - registered pulse, one per completed word
// Revision : 1.0 - initial release
// ============================================================================
module usr_nbit #(
    parameter int            N         = 4,
    parameter logic [N-1:0]  RESET_VAL = '0,
    parameter int            CW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_ah_in,
    input  logic          en_in,
    input  logic [2:0]    mode_in,
    input  logic          sr_in,
    input  logic          sl_in,
    input  logic [N-1:0]  d_par_in,
    output logic [N-1:0]  q_par_out,
    output logic          sr_out,
    output logic          sl_out,
    output logic [CW-1:0] cnt_out,
    output logic          word_ready_out
);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_SHR  = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_ROR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_LOAD = 3'b101;
    localparam logic [2:0] c_MODE_CLR  = 3'b110;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(N - 1);

    logic [N-1:0]  r_q;
    logic [CW-1:0] r_cnt;
    logic          r_word_ready;

    logic [N-1:0]  w_q_next;
    logic          w_is_shift;
    logic          w_restart;

    // Next register value for the selected operation.
    always_comb begin
        w_q_next = r_q;
        case (mode_in)
            c_MODE_HOLD: w_q_next = r_q;
            c_MODE_SHR:  w_q_next = {sr_in, r_q[N-1:1]};
            c_MODE_SHL:  w_q_next = {r_q[N-2:0], sl_in};
            c_MODE_ROR:  w_q_next = {r_q[0], r_q[N-1:1]};
            c_MODE_ROL:  w_q_next = {r_q[N-2:0], r_q[N-1]};
            c_MODE_LOAD: w_q_next = d_par_in;
            c_MODE_CLR:  w_q_next = '0;
            default:     w_q_next = r_q;
        endcase
    end

    // Only true serial shifts advance the word counter; rotates recirculate
    // existing data and so never complete a new word.
    assign w_is_shift = (mode_in == c_MODE_SHR) || (mode_in == c_MODE_SHL);
    // Load and clear discard any partially assembled word.
    assign w_restart  = (mode_in == c_MODE_LOAD) || (mode_in == c_MODE_CLR);

    always_ff @(posedge clk) begin
        if (reset_ah_in) begin
            r_q          <= RESET_VAL;
            r_cnt        <= '0;
            r_word_ready <= 1'b0;
        end else if (en_in) begin
            r_q <= w_q_next;
            if (w_is_shift) begin
                if (r_cnt == c_CNT_LAST) begin
                    // Wrap straight to zero so back-to-back words pulse
                    // every N shifts with no dead cycle.
                    r_cnt        <= '0;
                    r_word_ready <= 1'b1;
                end else begin
                    r_cnt        <= r_cnt + CW'(1);
                    r_word_ready <= 1'b0;
                end
            end else if (w_restart) begin
                r_cnt        <= '0;
                r_word_ready <= 1'b0;
            end else begin
                r_word_ready <= 1'b0;
            end
        end else begin
            r_word_ready <= 1'b0;
        end
    end

    assign q_par_out      = r_q;
    assign sr_out         = r_q[0];
    assign sl_out         = r_q[N-1];
    assign cnt_out        = r_cnt;
    assign word_ready_out = r_word_ready;

endmodule
`default_nettype wire
